// File: rtl/ddc_rd_ctrl.sv
// Read-side controller for the DDC result ring: fetches whole frames behind the write pointer
// and streams them as AXI-Stream with tlast, resynchronising when the writer laps the reader.
module ddc_rd_ctrl #(
    parameter int unsigned RING_DEPTH = 11521,
    parameter int unsigned FRAME_LEN  = 256,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned GUARD      = 64
) (
    input  logic        lbs_clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [13:0] ddc_conv_waddr,
    output logic [13:0] lbs_addr,
    input  logic [31:0] ddc_conv_data,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tlast,
    output logic        overrun,
    output logic [15:0] frame_cnt
);

    localparam logic [14:0] Depth15  = 15'(RING_DEPTH);
    localparam logic [14:0] Limit15  = 15'(RING_DEPTH - GUARD);
    localparam logic [14:0] Frame15  = 15'(FRAME_LEN);
    localparam logic [12:0] LastIdx  = 13'(FRAME_LEN - 1);
    localparam logic [13:0] PtrMax   = 14'(RING_DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StWait, StBurst, StDrain} state_e;

    state_e              state_q, state_d;
    logic [13:0]         rd_ptr_q, rd_ptr_d;
    logic [13:0]         lbs_addr_q, lbs_addr_d;
    logic [14:0]         avail_q, avail_d;
    logic [12:0]         issue_cnt_q, issue_cnt_d;
    logic                overrun_q;
    logic [15:0]         frame_cnt_q;
    logic [RD_LAT-1:0]   pipe_vld_q, pipe_last_q;
    logic [31:0]         fifo_data_q [4];
    logic [3:0]          fifo_last_q;
    logic [1:0]          wr_idx_q, rd_idx_q;
    logic [2:0]          buf_cnt_q;

    logic [3:0] inflight;
    logic       can_issue, issue, issue_last, resync, push, pop, tlast_hs;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(RD_LAT); i++) begin
            inflight = inflight + 4'(pipe_vld_q[i]);
        end
    end

    // Credit: words buffered plus reads in flight never exceed the FIFO depth.
    assign can_issue = (({1'b0, buf_cnt_q} + inflight) < 4'd4);
    assign push      = pipe_vld_q[RD_LAT-1];
    assign pop       = m_axis_tvalid & m_axis_tready;
    assign tlast_hs  = pop & m_axis_tlast;

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        lbs_addr_d  = lbs_addr_q;
        issue_cnt_d = issue_cnt_q;
        issue       = 1'b0;
        issue_last  = 1'b0;
        resync      = 1'b0;
        case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d  = StWait;
                    rd_ptr_d = ddc_conv_waddr;
                end
            end
            StWait: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (avail_q > Limit15) begin
                    rd_ptr_d = ddc_conv_waddr;
                    resync   = 1'b1;
                end else if (avail_q >= Frame15) begin
                    state_d     = StBurst;
                    issue_cnt_d = '0;
                end
            end
            StBurst: begin
                if (can_issue) begin
                    issue       = 1'b1;
                    lbs_addr_d  = rd_ptr_q;
                    rd_ptr_d    = (rd_ptr_q == PtrMax) ? 14'd0 : rd_ptr_q + 14'd1;
                    issue_cnt_d = issue_cnt_q + 13'd1;
                    if (issue_cnt_q == LastIdx) begin
                        issue_last = 1'b1;
                        state_d    = StDrain;
                    end
                end
            end
            StDrain: begin
                if (tlast_hs) begin
                    state_d = enable ? StWait : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Built from the next read pointer so a resync never sees a stale fill level.
    always_comb begin
        if (ddc_conv_waddr >= rd_ptr_d) begin
            avail_d = {1'b0, ddc_conv_waddr} - {1'b0, rd_ptr_d};
        end else begin
            avail_d = {1'b0, ddc_conv_waddr} + Depth15 - {1'b0, rd_ptr_d};
        end
    end

    always_ff @(posedge lbs_clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            rd_ptr_q    <= '0;
            lbs_addr_q  <= '0;
            avail_q     <= '0;
            issue_cnt_q <= '0;
            overrun_q   <= 1'b0;
            frame_cnt_q <= '0;
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
        end else begin
            state_q        <= state_d;
            rd_ptr_q       <= rd_ptr_d;
            lbs_addr_q     <= lbs_addr_d;
            avail_q        <= avail_d;
            issue_cnt_q    <= issue_cnt_d;
            overrun_q      <= resync;
            pipe_vld_q[0]  <= issue;
            pipe_last_q[0] <= issue_last;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_last_q[i] <= pipe_last_q[i-1];
            end
            if (tlast_hs) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge lbs_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                fifo_data_q[i] <= '0;
            end
            fifo_last_q <= '0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            buf_cnt_q   <= '0;
        end else begin
            if (push) begin
                fifo_data_q[wr_idx_q] <= ddc_conv_data;
                fifo_last_q[wr_idx_q] <= pipe_last_q[RD_LAT-1];
                wr_idx_q              <= wr_idx_q + 2'd1;
            end
            if (pop) begin
                rd_idx_q <= rd_idx_q + 2'd1;
            end
            case ({push, pop})
                2'b10:   buf_cnt_q <= buf_cnt_q + 3'd1;
                2'b01:   buf_cnt_q <= buf_cnt_q - 3'd1;
                default: buf_cnt_q <= buf_cnt_q;
            endcase
        end
    end

    assign lbs_addr      = lbs_addr_q;
    assign m_axis_tvalid = (buf_cnt_q != 3'd0);
    assign m_axis_tdata  = fifo_data_q[rd_idx_q];
    assign m_axis_tlast  = m_axis_tvalid & fifo_last_q[rd_idx_q];
    assign overrun       = overrun_q;
    assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_ddc_rd_ctrl.sv
// Bench for ddc_rd_ctrl: a ring-address stream model checks every accepted word, plus literal
// spot values for frame boundaries, ring wrap, overrun and reset.
module tb_ddc_rd_ctrl;

    localparam int DEPTH = 11521;
    localparam int FLEN  = 256;

    logic        lbs_clk = 1'b0;
    logic        rst     = 1'b1;
    logic        enable  = 1'b0;
    logic [13:0] waddr   = '0;
    logic [13:0] lbs_addr;
    logic [31:0] rdata   = '0;
    logic        tvalid, tready, tlast, overrun;
    logic [31:0] tdata;
    logic [15:0] frame_cnt;

    ddc_rd_ctrl dut (
        .lbs_clk        (lbs_clk),
        .rst            (rst),
        .enable         (enable),
        .ddc_conv_waddr (waddr),
        .lbs_addr       (lbs_addr),
        .ddc_conv_data  (rdata),
        .m_axis_tvalid  (tvalid),
        .m_axis_tready  (tready),
        .m_axis_tdata   (tdata),
        .m_axis_tlast   (tlast),
        .overrun        (overrun),
        .frame_cnt      (frame_cnt)
    );

    always #5 lbs_clk = ~lbs_clk;

    function automatic logic [31:0] word_of(input logic [13:0] a);
        return {2'b00, a, {2'b00, a} ^ 16'hA5C3};
    endfunction

    // Registered BRAM: data for the address seen at this edge appears after it.
    always @(posedge lbs_clk) rdata <= word_of(lbs_addr);

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Model: expected ring address of the next accepted word and position within its frame.
    int          exp_addr = 0;
    int          exp_idx = 0;
    int          exp_frames = 0;
    int          ovr_cnt = 0;
    bit          quiet = 1'b1;
    bit          rand_ready = 1'b0;
    logic        prev_stall = 1'b0;
    logic        prev_last = 1'b0;
    logic        prev_ovr = 1'b0;
    logic [31:0] prev_data = '0;
    logic [31:0] rx [FLEN];

    always @(negedge lbs_clk) begin
        if (rst) begin
            check("rst_tvalid", tvalid, 0);
            check("rst_tlast", tlast, 0);
            check("rst_tdata", tdata, 0);
            check("rst_lbs_addr", lbs_addr, 0);
            check("rst_overrun", overrun, 0);
            check("rst_frame_cnt", frame_cnt, 0);
            exp_idx    = 0;
            exp_frames = 0;
            prev_stall = 1'b0;
            prev_ovr   = 1'b0;
        end else begin
            check("frame_cnt", frame_cnt, exp_frames[15:0]);
            if (quiet) check("quiet_tvalid", tvalid, 0);
            if (prev_stall) begin
                check("stall_tvalid", tvalid, 1);
                check("stall_tdata", tdata, prev_data);
                check("stall_tlast", tlast, prev_last);
            end
            if (overrun) begin
                ovr_cnt++;
                check("overrun_width", prev_ovr, 0);
            end
            prev_ovr = overrun;
            if (tvalid && tready) begin
                check("tdata", tdata, word_of(exp_addr[13:0]));
                check("tlast", tlast, exp_idx == FLEN - 1);
                rx[exp_idx] = tdata;
                exp_addr = (exp_addr + 1) % DEPTH;
                if (exp_idx == FLEN - 1) begin
                    exp_idx = 0;
                    exp_frames++;
                end else begin
                    exp_idx++;
                end
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_last  = tlast;
        end
    end

    task automatic step();
        @(posedge lbs_clk);
        #1;
        if (rand_ready) tready = ($urandom_range(0, 9) < 3);
    endtask

    task automatic ramp(input int target);
        while (int'(waddr) != target) begin
            step();
            waddr = 14'((int'(waddr) + 1) % DEPTH);
        end
    endtask

    task automatic wait_frames(input int n, input int budget);
        int c = 0;
        while (exp_frames < n && c < budget) begin
            step();
            c++;
        end
        check("frame_timeout", exp_frames >= n, 1);
        repeat (3) step();
    endtask

    task automatic wait_idx(input int idx, input int budget);
        int c = 0;
        while (exp_idx < idx && c < budget) begin
            step();
            c++;
        end
        check("word_timeout", exp_idx >= idx, 1);
    endtask

    int ovr_before;

    initial begin
        tready = 1'b1;
        // Reset with inputs wiggling
        repeat (4) begin
            step();
            enable = ~enable;
            waddr  = waddr + 14'd37;
            tready = ~tready;
        end
        enable = 1'b0;
        waddr  = 14'd100;
        tready = 1'b1;
        step();
        rst = 1'b0;
        step();

        // Single frame 100..355
        exp_addr = 100;
        quiet    = 1'b0;
        enable   = 1'b1;
        repeat (3) step();
        ramp(356);
        wait_frames(1, 600);
        check("t2_frame_cnt", frame_cnt, 1);
        check("t2_first", rx[0], 32'h0064A5A7);
        check("t2_last", rx[255], 32'h0163A4A0);

        // Frame across the ring wrap 11400..11520, 0..134
        enable = 1'b0;
        repeat (5) step();
        waddr = 14'd11400;
        step();
        exp_addr = 11400;
        enable   = 1'b1;
        repeat (3) step();
        ramp(135);
        wait_frames(2, 600);
        check("t3_before_wrap", rx[120], 32'h2D0088C3);
        check("t3_after_wrap", rx[121], 32'h0000A5C3);
        check("t3_last", rx[255], 32'h0086A545);

        // Backpressure, ~30% ready
        rand_ready = 1'b1;
        ramp(391);
        wait_frames(3, 4000);
        rand_ready = 1'b0;
        tready     = 1'b1;
        step();
        check("t4_frame_cnt", frame_cnt, 3);
        check("t4_first", rx[0], 32'h0087A544);
        check("t4_last", rx[255], 32'h0186A445);

        // Overrun: avail jumps to 11500
        quiet      = 1'b1;
        ovr_before = ovr_cnt;
        waddr      = 14'd370;
        exp_addr   = 370;
        repeat (20) step();
        check("t5_overrun_pulses", ovr_cnt - ovr_before, 1);
        check("t5_frame_cnt", frame_cnt, 3);
        quiet = 1'b0;

        // Enable dropped mid-frame: frame completes, then no further frames
        ramp(626);
        wait_idx(50, 600);
        enable = 1'b0;
        wait_frames(4, 600);
        quiet = 1'b1;
        ramp(926);
        check("t6_idle_frame_cnt", frame_cnt, 4);
        quiet = 1'b0;

        // Reset mid-frame
        exp_addr = 926;
        enable   = 1'b1;
        repeat (3) step();
        ramp(1182);
        wait_idx(10, 600);
        rst    = 1'b1;
        enable = 1'b0;
        quiet  = 1'b1;
        step();
        check("t6_rst_tvalid", tvalid, 0);
        check("t6_rst_frame_cnt", frame_cnt, 0);
        rst = 1'b0;
        repeat (10) step();
        check("t6_post_tvalid", tvalid, 0);
        check("t6_post_frame_cnt", frame_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
